stack_mem_ctrl: RTL and testbench
=================================

# stack_mem_ctrl

Memory-side initiator that sits between the datapath and the data memory. It accepts load/store/push/pop requests over a valid/ready handshake, owns the stack pointer, and drives the data memory's MemAddr/MemRD/MemWR/StackOP/stack_pointer/MemDataIn ports. It absorbs the memory's one-cycle registered read latency and returns read data or an error over a response handshake. Stack overflow, stack underflow and out-of-region accesses are detected before any memory strobe is issued.

## Interface
Parameters:
- MEM_DEPTH, 16: data memory depth in 32-bit words.
- STACK_BASE, MEM_DEPTH/2: first stack word; words below it form the normal data region.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  00 load, 01 store, 10 push, 11 pop.
- req_addr  in  32  word address; used by load/store only.
- req_wdata  in  32  write data for store and push.
- req_peek  in  1  with pop: read top of stack without popping (only when STACK_PEEK_EN is defined).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load/pop data; 0 for writes and errors.
- rsp_err  out  1  request rejected; no memory access was made.
- MemAddr  out  32  to data memory.
- MemRD  out  1  to data memory.
- MemWR  out  1  to data memory.
- StackOP  out  1  to data memory.
- stack_pointer  out  32  to data memory.
- MemDataIn  out  32  to data memory.
- MemDataOut  in  32  from data memory; registered, valid one edge after MemRD.
- sp_value  out  32  current stack pointer, for debug.

## Operation
- Stack pointer SP points at the next free slot. Empty when SP == STACK_BASE; full when SP == MEM_DEPTH-1, because the memory never writes the last word. Capacity is MEM_DEPTH-1-STACK_BASE entries (7 by default).
- Load/store: the request is legal only if req_addr < STACK_BASE. It drives MemAddr=req_addr with StackOP=0.
- Push: legal only if not full. It drives stack_pointer=SP, StackOP=1, MemWR=1 and MemDataIn=req_wdata, then SP <= SP+1.
- Pop: legal only if not empty. It drives stack_pointer=SP-1, StackOP=1, MemRD=1, and SP <= SP-1 on the issue edge.
- Illegal requests go straight to RESP with rsp_err=1 and rsp_rdata=0. No strobe is issued and SP is unchanged.
- FSM states:
  - IDLE: req_ready=1. On accept, go to ISSUE, or to RESP on error.
  - ISSUE: exactly one strobe cycle. Writes go to RESP; reads go to WAIT.
  - WAIT: capture MemDataOut into rsp_rdata, then go to RESP.
  - RESP: rsp_valid=1 until rsp_ready, then go to IDLE.
- Request fields are latched on accept, so the datapath may change them afterwards.
- MemRD and MemWR are never both high. Each is high for at most one cycle per request.

## Timing
- Reset values: state IDLE, SP=STACK_BASE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, MemRD=0, MemWR=0, StackOP=0, MemAddr=0, MemDataIn=0, stack_pointer=STACK_BASE, sp_value=STACK_BASE.
- Write latency: accept edge T0, strobe during cycle T0..T1, rsp_valid from T1.
- Read latency: accept at T0, MemRD during T0..T1, memory outputs at T1, capture at T2, rsp_valid from T2.
- Error latency: rsp_valid one cycle after accept.
- req_ready is low from the accept edge until the cycle after the response handshake, so at most one request is outstanding.
- rsp_ready held low stalls the FSM in RESP. rsp_rdata and rsp_err stay stable while stalled.
- Asserting rst_n low mid-operation returns the block to reset values immediately. Any in-flight strobe is dropped and SP reverts to STACK_BASE.

## Configuration
- STACK_PEEK_EN defined: pop with req_peek=1 reads memory at SP-1 and leaves SP unchanged; it still errors when the stack is empty.
- STACK_PEEK_EN undefined: req_peek is ignored and every pop decrements SP.

## Test plan
- Reset, then store 0x12345678 to address 4, then load address 4: write response with err=0; load response rdata=0x12345678 exactly 2 cycles after MemRD.
- Push 0xA1, 0xA2, 0xA3, then pop three times: rdata 0xA3, 0xA2, 0xA1; SP goes 8→11→8.
- Push 8 times from reset: the first 7 succeed (SP=15); the 8th returns err=1 with no MemWR pulse.
- Pop from empty, and store to address 9: both return err=1 with MemRD=MemWR=0 throughout and SP=8.
- Hold rsp_ready low for 5 cycles after a load: rsp_valid and rsp_rdata stay stable, req_ready stays 0. Pull rst_n low mid-read: all outputs return to reset values within the same cycle.
- With STACK_PEEK_EN: push 0x55, then peek twice, then pop: all three return 0x55; SP goes 9, 9, 9, 8.

Source files
------------

// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl
//   Sits between the datapath and the data memory. It accepts one
//   load/store/push/pop request at a time and owns the stack pointer. It
//   drives the memory strobes for a single cycle, absorbs the memory's
//   one-cycle registered read latency and returns data or an error on a
//   response handshake. Overflow, underflow and out-of-region accesses are
//   rejected before any strobe is issued.
//
//   Optional feature macro: STACK_PEEK_EN. When defined, a pop with
//   req_peek=1 reads the top of stack without moving SP. When undefined,
//   req_peek is ignored.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op                     00 load, 01 store, 10 push, 11 pop
//   req_addr, req_wdata        load/store word address, store/push data
//   req_peek                   pop modifier (STACK_PEEK_EN only)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         read data (0 on writes/errors), reject flag
//   MemAddr, MemRD, MemWR,
//   StackOP, stack_pointer,
//   MemDataIn                  data memory controls (registered)
//   MemDataOut                 data memory read data (valid one edge after MemRD)
//   sp_value                   current stack pointer (debug)
module stack_mem_ctrl #(
    parameter int MEM_DEPTH  = 16,
    parameter int STACK_BASE = MEM_DEPTH / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_peek,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] MemAddr,
    output logic        MemRD,
    output logic        MemWR,
    output logic        StackOP,
    output logic [31:0] stack_pointer,
    output logic [31:0] MemDataIn,
    input  logic [31:0] MemDataOut,
    output logic [31:0] sp_value
);

    localparam logic [1:0]  OP_LOAD  = 2'b00;
    localparam logic [1:0]  OP_STORE = 2'b01;
    localparam logic [1:0]  OP_PUSH  = 2'b10;
    localparam logic [1:0]  OP_POP   = 2'b11;

    // The memory never writes its last word, so the stack is full one
    // slot below the top of memory.
    localparam logic [31:0] SP_EMPTY = 32'(STACK_BASE);
    localparam logic [31:0] SP_FULL  = 32'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sp_q, sp_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        stack_op_q, stack_op_d;
    logic [31:0] stack_ptr_q, stack_ptr_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;

    logic        peek;

`ifdef STACK_PEEK_EN
    assign peek = req_peek;
`else
    // Peek is compiled out: every pop moves SP.
    assign peek = req_peek & 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        stack_op_d    = 1'b0;
        stack_ptr_d   = stack_ptr_q;
        mem_data_in_d = mem_data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    // All strobe controls are captured here, so the
                    // datapath may change the request fields afterwards.
                    req_ready_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_ISSUE;
                    case (req_op)
                        OP_LOAD, OP_STORE: begin
                            if (req_addr < SP_EMPTY) begin
                                mem_addr_d = req_addr;
                                if (req_op == OP_LOAD) begin
                                    mem_rd_d = 1'b1;
                                end else begin
                                    mem_wr_d      = 1'b1;
                                    mem_data_in_d = req_wdata;
                                end
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end
                        OP_PUSH: begin
                            if (sp_q < SP_FULL) begin
                                stack_op_d    = 1'b1;
                                mem_wr_d      = 1'b1;
                                stack_ptr_d   = sp_q;
                                mem_data_in_d = req_wdata;
                                sp_d          = sp_q + 32'd1;
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end
                        default: begin // OP_POP
                            if (sp_q > SP_EMPTY) begin
                                stack_op_d  = 1'b1;
                                mem_rd_d    = 1'b1;
                                stack_ptr_d = sp_q - 32'd1;
                                if (!peek) begin
                                    sp_d = sp_q - 32'd1;
                                end
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end
                    endcase
                    // Rejected requests skip the memory entirely.
                    if (rsp_err_d) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Strobes were high for exactly this cycle and default low
                // again. Reads wait one more edge for registered memory data.
                if (mem_rd_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                rsp_rdata_d = MemDataOut;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            default: begin // ST_RESP
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sp_q          <= SP_EMPTY;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            stack_op_q    <= 1'b0;
            stack_ptr_q   <= SP_EMPTY;
            mem_data_in_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            stack_op_q    <= stack_op_d;
            stack_ptr_q   <= stack_ptr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign MemAddr       = mem_addr_q;
    assign MemRD         = mem_rd_q;
    assign MemWR         = mem_wr_q;
    assign StackOP       = stack_op_q;
    assign stack_pointer = stack_ptr_q;
    assign MemDataIn     = mem_data_in_q;
    assign sp_value      = sp_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed testbench for stack_mem_ctrl with a small registered-read
// data memory model attached to the memory ports.
module tb_stack_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_peek = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] MemAddr;
    logic        MemRD;
    logic        MemWR;
    logic        StackOP;
    logic [31:0] stack_pointer;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut = 32'd0;
    logic [31:0] sp_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_mem_ctrl #(.MEM_DEPTH(16), .STACK_BASE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_peek(req_peek),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR), .StackOP(StackOP),
        .stack_pointer(stack_pointer), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut), .sp_value(sp_value)
    );

    // Data memory model: registered read, last word never written.
    logic [31:0] mem [16];
    logic [31:0] mem_idx;
    assign mem_idx = StackOP ? stack_pointer : MemAddr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (MemWR && mem_idx < 32'd15) mem[mem_idx[3:0]] <= MemDataIn;
        if (MemRD) MemDataOut <= mem[mem_idx[3:0]];
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (MemRD && MemWR) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: MemRD=%b MemWR=%b required not both 1", MemRD, MemWR);
        end
    end

    localparam logic [1:0] LD = 2'b00, ST = 2'b01, PU = 2'b10, PO = 2'b11;

    // Drives one request with rsp_ready high and reports what came back.
    // lat = negedges after the accept edge until rsp_valid (0 = timeout).
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic peek,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nrd, output int nwr);
        bit got;
        got = 0; lat = 0; nrd = 0; nwr = 0; rdata = 32'hFFFF_FFFF; err = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        req_peek = peek; rsp_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble fields: the DUT must have latched them.
        req_valid = 1'b0; req_op = ~op; req_addr = 32'hDEAD_BEEF;
        req_wdata = 32'hCAFE_F00D; req_peek = ~peek;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (MemRD) nrd++;
            if (MemWR) nwr++;
            if (rsp_valid) begin
                got = 1; lat = n; rdata = rsp_rdata; err = rsp_err;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_handshake: ready=%b valid=%b err=%b rdata=%h required 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (MemRD !== 1'b0 || MemWR !== 1'b0 || StackOP !== 1'b0 || MemAddr !== 32'd0 || MemDataIn !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: rd=%b wr=%b sop=%b addr=%h din=%h required all 0",
                     MemRD, MemWR, StackOP, MemAddr, MemDataIn);
        end
        checks++;
        if (sp_value !== 32'd8 || stack_pointer !== 32'd8) begin
            errors++;
            $display("FAIL reset_sp: sp=%0d stack_pointer=%0d required 8 8", sp_value, stack_pointer);
        end
        $display("reset: sp=%0d ready=%b", sp_value, req_ready);
    endtask

    task automatic test_load_store();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(ST, 32'd4, 32'h1234_5678, 1'b0, rd, er, lat, nrd, nwr);
        $display("store [4]=12345678: err=%b lat=%0d wr=%0d", er, lat, nwr);
        checks++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != 2 || nwr != 1 || nrd != 0) begin
            errors++;
            $display("FAIL store: err=%b rdata=%h lat=%0d wr=%0d rd=%0d required 0 0 2 1 0", er, rd, lat, nwr, nrd);
        end
        checks++;
        if (mem[4] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_mem: mem[4]=%h required 12345678", mem[4]);
        end
        do_req(LD, 32'd4, 32'd0, 1'b0, rd, er, lat, nrd, nwr);
        $display("load [4]: rdata=%h err=%b lat=%0d", rd, er, lat);
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0 || lat != 3 || nrd != 1 || nwr != 0) begin
            errors++;
            $display("FAIL load: rdata=%h err=%b lat=%0d rd=%0d wr=%0d required 12345678 0 3 1 0", rd, er, lat, nrd, nwr);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        logic [31:0] vals [3];
        vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
        for (int i = 0; i < 3; i++) begin
            do_req(PU, 32'd0, vals[i], 1'b0, rd, er, lat, nrd, nwr);
            $display("push %h: err=%b sp=%0d", vals[i], er, sp_value);
            checks++;
            if (er !== 1'b0 || lat != 2 || nwr != 1 || sp_value !== 32'(9 + i)) begin
                errors++;
                $display("FAIL push_%0d: err=%b lat=%0d wr=%0d sp=%0d required 0 2 1 %0d", i, er, lat, nwr, sp_value, 9 + i);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            do_req(PO, 32'd0, 32'd0, 1'b0, rd, er, lat, nrd, nwr);
            $display("pop: rdata=%h err=%b sp=%0d", rd, er, sp_value);
            checks++;
            if (rd !== vals[i] || er !== 1'b0 || lat != 3 || sp_value !== 32'(8 + i)) begin
                errors++;
                $display("FAIL pop_%0d: rdata=%h err=%b lat=%0d sp=%0d required %h 0 3 %0d", i, rd, er, lat, sp_value, vals[i], 8 + i);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_req(PU, 32'd0, 32'h100 + 32'(i), 1'b0, rd, er, lat, nrd, nwr);
            $display("push #%0d: err=%b wr=%0d sp=%0d", i, er, nwr, sp_value);
            if (i < 7) begin
                checks++;
                if (er !== 1'b0 || nwr != 1) begin
                    errors++;
                    $display("FAIL fill_%0d: err=%b wr=%0d required 0 1", i, er, nwr);
                end
            end else begin
                checks++;
                if (er !== 1'b1 || nwr != 0 || lat != 1 || sp_value !== 32'd15) begin
                    errors++;
                    $display("FAIL overflow: err=%b wr=%0d lat=%0d sp=%0d required 1 0 1 15", er, nwr, lat, sp_value);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        apply_reset();
        do_req(PO, 32'd0, 32'd0, 1'b0, rd, er, lat, nrd, nwr);
        $display("pop empty: err=%b rd=%0d wr=%0d sp=%0d", er, nrd, nwr, sp_value);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nrd != 0 || nwr != 0 || sp_value !== 32'd8) begin
            errors++;
            $display("FAIL underflow: err=%b rdata=%h lat=%0d rd=%0d wr=%0d sp=%0d required 1 0 1 0 0 8", er, rd, lat, nrd, nwr, sp_value);
        end
        do_req(ST, 32'd9, 32'h5A5A_5A5A, 1'b0, rd, er, lat, nrd, nwr);
        $display("store [9]: err=%b rd=%0d wr=%0d sp=%0d", er, nrd, nwr, sp_value);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nrd != 0 || nwr != 0 || sp_value !== 32'd8) begin
            errors++;
            $display("FAIL bad_addr: err=%b rdata=%h lat=%0d rd=%0d wr=%0d sp=%0d required 1 0 1 0 0 8", er, rd, lat, nrd, nwr, sp_value);
        end
        // Boundary: address 7 is the last legal data word.
        do_req(ST, 32'd7, 32'h0000_0077, 1'b0, rd, er, lat, nrd, nwr);
        $display("store [7]: err=%b wr=%0d", er, nwr);
        checks++;
        if (er !== 1'b0 || nwr != 1) begin
            errors++;
            $display("FAIL addr7: err=%b wr=%0d required 0 1", er, nwr);
        end
    endtask

    task automatic test_stall();
        bit got = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = LD; req_addr = 32'd4; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'd0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stall_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b rdata=%h err=%b ready=%b required 1 12345678 0 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        $display("stall: 5 cycles held, rdata=%h", rsp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(PU, 32'd0, 32'h0000_00B1, 1'b0, rd, er, lat, nrd, nwr);
        do_req(PU, 32'd0, 32'h0000_00B2, 1'b0, rd, er, lat, nrd, nwr);
        @(negedge clk);
        req_valid = 1'b1; req_op = PO;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (MemRD !== 1'b1 || sp_value !== 32'd9) begin
            errors++;
            $display("FAIL mid_pre: rd=%b sp=%0d required 1 9", MemRD, sp_value);
        end
        #1 rst_n = 1'b0;
        #1;
        $display("reset mid-read: rd=%b sp=%0d ready=%b", MemRD, sp_value, req_ready);
        checks++;
        if (MemRD !== 1'b0 || MemWR !== 1'b0 || StackOP !== 1'b0 || sp_value !== 32'd8 ||
            stack_pointer !== 32'd8 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || MemAddr !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: rd=%b wr=%b sop=%b sp=%0d stkp=%0d ready=%b valid=%b addr=%h required 0 0 0 8 8 1 0 0",
                     MemRD, MemWR, StackOP, sp_value, stack_pointer, req_ready, rsp_valid, MemAddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_peek();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(PU, 32'd0, 32'h55, 1'b0, rd, er, lat, nrd, nwr);
        checks++;
        if (er !== 1'b0 || sp_value !== 32'd9) begin
            errors++;
            $display("FAIL peek_push: err=%b sp=%0d required 0 9", er, sp_value);
        end
`ifdef STACK_PEEK_EN
        for (int i = 0; i < 2; i++) begin
            do_req(PO, 32'd0, 32'd0, 1'b1, rd, er, lat, nrd, nwr);
            $display("peek: rdata=%h sp=%0d", rd, sp_value);
            checks++;
            if (rd !== 32'h55 || er !== 1'b0 || nrd != 1 || sp_value !== 32'd9) begin
                errors++;
                $display("FAIL peek_%0d: rdata=%h err=%b rd=%0d sp=%0d required 55 0 1 9", i, rd, er, nrd, sp_value);
            end
        end
        do_req(PO, 32'd0, 32'd0, 1'b0, rd, er, lat, nrd, nwr);
`else
        // Peek disabled: req_peek must not stop the pop.
        do_req(PO, 32'd0, 32'd0, 1'b1, rd, er, lat, nrd, nwr);
`endif
        $display("pop: rdata=%h sp=%0d", rd, sp_value);
        checks++;
        if (rd !== 32'h55 || er !== 1'b0 || sp_value !== 32'd8) begin
            errors++;
            $display("FAIL peek_pop: rdata=%h err=%b sp=%0d required 55 0 8", rd, er, sp_value);
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_push_pop();
        test_overflow();
        test_errors();
        test_stall();
        test_reset_mid_read();
        test_peek();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
